// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle for shared_reg_arbiter: four requesters' write requests and data in,
// grant/ack and shared register contents out. The slave modport belongs to the arbiter.
interface shared_reg_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       REQ;
  logic [WIDTH-1:0] DATA0;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [WIDTH-1:0] DATA3;
  logic             CLR;
  logic [3:0]       GNT;
  logic [3:0]       ACK;
  logic [WIDTH-1:0] Q;
  logic             Q_VALID;
  logic [1:0]       Q_OWNER;
  logic             BUSY;
  logic [1:0]       DBG_STATE;

  modport master (
    output REQ, DATA0, DATA1, DATA2, DATA3, CLR,
    input  GNT, ACK, Q, Q_VALID, Q_OWNER, BUSY, DBG_STATE
  );

  modport slave (
    input  REQ, DATA0, DATA1, DATA2, DATA3, CLR,
    output GNT, ACK, Q, Q_VALID, Q_OWNER, BUSY, DBG_STATE
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Four-requester arbiter guarding one shared register (IDLE -> GRANT -> ACK per write).
// Define SHARED_REG_RR_EN for round-robin arbitration; default is fixed priority (0 highest).
module shared_reg_arbiter #(
  parameter int WIDTH = 8
) (
  input logic                 CLK,
  input logic                 RST,
  shared_reg_arbiter_if.slave bus
);

  // Handshake: a requester holds REQ[i] and DATAi from assertion until it sees ACK[i];
  // dropping REQ[i] while GNT[i] is high aborts the write without an ACK.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_gnt;
  logic [3:0]       r_ack;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic [1:0]       r_q_owner;
  logic [1:0]       r_winner;
  logic [1:0]       w_sel;
  logic             w_write;
  logic [WIDTH-1:0] w_data;

`ifdef SHARED_REG_RR_EN
  logic [1:0] r_ptr;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_sel = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.REQ[r_ptr + 2'(k)]) w_sel = r_ptr + 2'(k);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)          r_ptr <= 2'd0;
    else if (w_write) r_ptr <= r_winner + 2'd1;
  end
`else
  always_comb begin
    w_sel = 2'd0;
    if (bus.REQ[0])      w_sel = 2'd0;
    else if (bus.REQ[1]) w_sel = 2'd1;
    else if (bus.REQ[2]) w_sel = 2'd2;
    else if (bus.REQ[3]) w_sel = 2'd3;
  end
`endif

  always_comb begin
    case (r_winner)
      2'd0:    w_data = bus.DATA0;
      2'd1:    w_data = bus.DATA1;
      2'd2:    w_data = bus.DATA2;
      default: w_data = bus.DATA3;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.REQ) w_state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (bus.REQ[r_winner]) begin
          w_write     = 1'b1;
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 4'd0;
      r_ack    <= 4'd0;
      r_winner <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= 4'd0;
      r_ack   <= 4'd0;
      if (r_state == ST_IDLE && |bus.REQ) begin
        r_winner <= w_sel;
        r_gnt    <= 4'b0001 << w_sel;
      end
      if (w_write) r_ack <= 4'b0001 << r_winner;
    end
  end

  // A write in the same cycle as CLR takes precedence over the clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_q_owner <= 2'd0;
    end else if (w_write) begin
      r_q       <= w_data;
      r_q_valid <= 1'b1;
      r_q_owner <= r_winner;
    end else if (bus.CLR) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_q_owner <= 2'd0;
    end
  end

  assign bus.GNT       = r_gnt;
  assign bus.ACK       = r_ack;
  assign bus.Q         = r_q;
  assign bus.Q_VALID   = r_q_valid;
  assign bus.Q_OWNER   = r_q_owner;
  assign bus.BUSY      = (r_state != ST_IDLE);
  assign bus.DBG_STATE = r_state;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed-vector bench for shared_reg_arbiter: inputs change and outputs are checked
// on the falling edge, so every check sees the state left by the preceding rising edge.
module tb_shared_reg_arbiter;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;

  shared_reg_arbiter_if #(.WIDTH(8)) bus ();

  shared_reg_arbiter #(.WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    bus.REQ = 4'd0;
    bus.CLR = 1'b0;
    step();
    step();
    chk("rst_gnt",   32'(bus.GNT), 32'h0);
    chk("rst_ack",   32'(bus.ACK), 32'h0);
    chk("rst_q",     32'(bus.Q), 32'h0);
    chk("rst_valid", 32'(bus.Q_VALID), 32'h0);
    chk("rst_owner", 32'(bus.Q_OWNER), 32'h0);
    chk("rst_busy",  32'(bus.BUSY), 32'h0);
    RST = 1'b0;
  endtask

  // Expected grant index for the k-th write with all four requesting from pointer 0.
  function automatic int exp_winner(input int k);
`ifdef SHARED_REG_RR_EN
    return k % 4;
`else
    return 0;
`endif
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    RST       = 1'b1;
    bus.REQ   = 4'd0;
    bus.CLR   = 1'b0;
    bus.DATA0 = 8'h10;
    bus.DATA1 = 8'h11;
    bus.DATA2 = 8'h12;
    bus.DATA3 = 8'h13;

    // Single write from requester 2
    do_reset();
    bus.REQ   = 4'b0100;
    bus.DATA2 = 8'hA5;
    step();
    chk("s1_gnt",  32'(bus.GNT), 32'h4);
    chk("s1_busy", 32'(bus.BUSY), 32'h1);
    chk("s1_ack0", 32'(bus.ACK), 32'h0);
    step();
    chk("s1_q",     32'(bus.Q), 32'hA5);
    chk("s1_owner", 32'(bus.Q_OWNER), 32'h2);
    chk("s1_valid", 32'(bus.Q_VALID), 32'h1);
    chk("s1_ack",   32'(bus.ACK), 32'h4);
    chk("s1_gnt0",  32'(bus.GNT), 32'h0);
    bus.REQ = 4'd0;
    step();
    chk("s1_idle", 32'(bus.BUSY), 32'h0);
    chk("s1_ackd", 32'(bus.ACK), 32'h0);

    // All four requesting continuously
    do_reset();
    bus.DATA2 = 8'h12;
    bus.REQ   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("s2_gnt", 32'(bus.GNT), 32'(4'b0001 << exp_winner(k)));
      step();
      chk("s2_ack",   32'(bus.ACK), 32'(4'b0001 << exp_winner(k)));
      chk("s2_q",     32'(bus.Q), 32'h10 + 32'(exp_winner(k)));
      chk("s2_owner", 32'(bus.Q_OWNER), 32'(exp_winner(k)));
      step();
      chk("s2_idle", 32'(bus.BUSY), 32'h0);
    end
    bus.REQ = 4'd0;

    // Abort in GRANT, then a fresh request resolves from pointer 0
    do_reset();
    bus.REQ = 4'b0010;
    step();
    chk("s3_gnt", 32'(bus.GNT), 32'h2);
    bus.REQ = 4'd0;
    step();
    chk("s3_ack",   32'(bus.ACK), 32'h0);
    chk("s3_busy",  32'(bus.BUSY), 32'h0);
    chk("s3_q",     32'(bus.Q), 32'h0);
    chk("s3_valid", 32'(bus.Q_VALID), 32'h0);
    bus.REQ = 4'b0011;
    step();
    chk("s3_gnt2", 32'(bus.GNT), 32'h1);
    step();
    chk("s3_ack2", 32'(bus.ACK), 32'h1);
    chk("s3_q2",   32'(bus.Q), 32'h10);
    bus.REQ = 4'd0;
    step();

    // Winner stays latched when another requester rises during GRANT
    bus.REQ = 4'b0100;
    step();
    chk("s4_gnt", 32'(bus.GNT), 32'h4);
    bus.REQ = 4'b0101;
    step();
    chk("s4_ack",   32'(bus.ACK), 32'h4);
    chk("s4_owner", 32'(bus.Q_OWNER), 32'h2);
    chk("s4_q",     32'(bus.Q), 32'h12);
    bus.REQ = 4'd0;
    step();

    // CLR colliding with a write loses; CLR alone clears
    bus.REQ   = 4'b0010;
    bus.DATA1 = 8'h3C;
    step();
    chk("s5_gnt", 32'(bus.GNT), 32'h2);
    bus.CLR = 1'b1;
    step();
    chk("s5_q",     32'(bus.Q), 32'h3C);
    chk("s5_valid", 32'(bus.Q_VALID), 32'h1);
    chk("s5_owner", 32'(bus.Q_OWNER), 32'h1);
    bus.REQ = 4'd0;
    step();
    chk("s5_clr_q",     32'(bus.Q), 32'h0);
    chk("s5_clr_valid", 32'(bus.Q_VALID), 32'h0);
    chk("s5_clr_owner", 32'(bus.Q_OWNER), 32'h0);
    chk("s5_clr_busy",  32'(bus.BUSY), 32'h0);
    bus.CLR = 1'b0;
    step();

    // RST in GRANT aborts; held request is re-granted after release
    bus.REQ   = 4'b1000;
    bus.DATA3 = 8'h77;
    step();
    chk("s6_gnt",  32'(bus.GNT), 32'h8);
    chk("s6_busy", 32'(bus.BUSY), 32'h1);
    RST = 1'b1;
    step();
    chk("s6_rst_gnt",   32'(bus.GNT), 32'h0);
    chk("s6_rst_ack",   32'(bus.ACK), 32'h0);
    chk("s6_rst_q",     32'(bus.Q), 32'h0);
    chk("s6_rst_valid", 32'(bus.Q_VALID), 32'h0);
    chk("s6_rst_busy",  32'(bus.BUSY), 32'h0);
    RST = 1'b0;
    step();
    chk("s6_gnt2", 32'(bus.GNT), 32'h8);
    step();
    chk("s6_ack2",   32'(bus.ACK), 32'h8);
    chk("s6_q2",     32'(bus.Q), 32'h77);
    chk("s6_owner2", 32'(bus.Q_OWNER), 32'h3);
    bus.REQ = 4'd0;
    step();
    chk("s6_idle", 32'(bus.BUSY), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the shared register and of every requester data port.
REQ-002 Port: CLK  input  1  rising-edge clock; all state updates on posedge CLK only.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: REQ  input  4  per-requester write request, bit i = requester i.
REQ-005 Port: DATA0..DATA3  input  WIDTH each  write data of requester 0..3.
REQ-006 Port: CLR  input  1  synchronous clear of the shared register.
REQ-007 Port: GNT  output  4  registered one-hot grant; all-zero when no grant.
REQ-008 Port: ACK  output  4  registered one-hot, one-cycle write-complete pulse.
REQ-009 Port: Q  output  WIDTH  shared register contents.
REQ-010 Port: Q_VALID  output  1  high once Q holds requester-written data.
REQ-011 Port: Q_OWNER  output  2  index of the requester that last wrote Q.
REQ-012 Port: BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 FSM states: IDLE, GRANT, ACK; the state register is the only source of BUSY, which is high in GRANT and ACK.
REQ-014 IDLE: if REQ != 0, the block selects a winner per REQ-020/REQ-030, drives GNT[winner]=1 in the next cycle, and moves to GRANT; if REQ == 0, it stays in IDLE with GNT=0.
REQ-015 GRANT with REQ[winner]=1: on the next edge, Q<=DATA[winner], Q_OWNER<=winner, Q_VALID<=1, ACK[winner]<=1, GNT<=0, and the state moves to ACK.
REQ-016 GRANT with REQ[winner]=0 (abort): on the next edge, GNT<=0 and the state moves to IDLE; Q, Q_VALID, Q_OWNER and the priority pointer are unchanged, and no ACK is issued.
REQ-017 ACK state: ACK is high for exactly this one cycle, GNT=0, and the next state is IDLE unconditionally; REQ is ignored during ACK.
REQ-018 Latency: REQ sampled in IDLE at edge N gives GNT high in cycle N+1, Q updated and ACK high in cycle N+2, and BUSY low again in cycle N+3; minimum spacing between two writes is 3 cycles.
REQ-019 Requester protocol: REQ and DATAi are held stable from assertion until ACK; REQ is dropped in the cycle ACK is seen, otherwise the requester re-enters arbitration.
REQ-020 Winner selection is combinational on REQ sampled in IDLE only; GNT and ACK are never multi-hot.
REQ-021 CLR=1 in any state: Q<=0, Q_VALID<=0, Q_OWNER<=0 on the next edge, and the FSM state is unaffected.
REQ-022 A CLR coincident with a GRANT-state write (REQ-015) loses: the write takes effect and Q_VALID=1.
REQ-023 A winner is latched at IDLE exit; REQ changes on other bits during GRANT do not alter it.

Reset
REQ-024 RST=1 at a clock edge forces state=IDLE, GNT=0, ACK=0, Q=0, Q_VALID=0, Q_OWNER=0, BUSY=0 and priority pointer=0, overriding CLR and any write.
REQ-025 RST asserted during GRANT or ACK aborts the transaction with no write and no ACK.
REQ-026 After RST deasserts, REQ is first sampled at the following edge.

Configuration
REQ-027 Macro SHARED_REG_RR_EN selects the arbitration policy.
REQ-028 With SHARED_REG_RR_EN defined, arbitration is round-robin via a 2-bit pointer P: search starts at requester P and wraps 3->0.
REQ-029 With SHARED_REG_RR_EN defined, P<=winner+1 (mod 4) only on a completed write; aborts and CLR do not move P.
REQ-030 Without SHARED_REG_RR_EN, arbitration is fixed priority (requester 0 highest, 3 lowest), no pointer register exists, and Q_OWNER still reports the writer.

Verification
REQ-031 Scenario: after RST, REQ=4'b0100 and DATA2=8'hA5 held -> GNT=4'b0100 in cycle +1, Q=8'hA5, Q_OWNER=2, Q_VALID=1 and ACK=4'b0100 in cycle +2, BUSY=0 in cycle +3.
REQ-032 Scenario: REQ=4'b1111 held with DATAi=8'h10+i -> RR build grants order 0,1,2,3,0; fixed build grants 0 repeatedly; each write spaced 3 cycles.
REQ-033 Scenario: REQ=4'b0010, then REQ[1] dropped during GRANT -> no ACK, Q unchanged, back in IDLE; RR pointer unchanged (next REQ=4'b0011 grants 0 when P=0).
REQ-034 Scenario: CLR=1 in the same cycle as a GRANT-state write of 8'h3C -> Q=8'h3C, Q_VALID=1; CLR alone one cycle later -> Q=0, Q_VALID=0, Q_OWNER=0.
REQ-035 Scenario: RST pulsed in GRANT with REQ=4'b1000 -> all outputs at reset values next cycle, no ACK; with REQ still held, a new grant to 3 follows RST release per REQ-018.
